syn_wm8731_i2c_cfg_ctrl: RTL and testbench
==========================================

SYN_WM8731_I2C_CFG_CTRL -- requirements
Module: syn_wm8731_i2c_cfg_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and all flops SHALL clear on reset assertion.
REQ-002 Parameters (name, default, meaning) SHALL be:
- P_LB_DATA_W, 16, local bus data width
- P_LB_ADDR_W, 8, local bus address width
- P_SCL_QTR_DIV, 125, clk cycles per SCL quarter-period (100 kHz at 50 MHz)
- P_DEV_ADDR, 7'h1A, WM8731 7-bit I2C address
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk_ir, in, 1, clock
- rst_sync_l, in, 1, async active-low reset
- lb_wr_en, in, 1, register write strobe
- lb_rd_en, in, 1, register read strobe
- lb_addr, in, P_LB_ADDR_W, register address
- lb_wr_data, in, P_LB_DATA_W, write data
- lb_wr_valid, out, 1, write acknowledge
- lb_rd_valid, out, 1, read data valid
- lb_rd_data, out, P_LB_DATA_W, read data
- i2c_scl, out, 1, serial clock
- i2c_sda_o, out, 1, SDA drive value, always 0
- i2c_sda_oe, out, 1, 1 = pull SDA low, 0 = release
- i2c_sda_i, in, 1, sampled SDA line
- cfg_done_p, out, 1, one-cycle pulse when a transaction ends

Function
REQ-004 Registers SHALL be:
- CFG_CTRL 0x20: bit0 = start; write-only trigger that reads back 0
- CFG_DATA 0x21 (R/W): [15:9] codec register address, [8:0] codec register data
- CFG_STATUS 0x22 (RO): bit0 = busy, bit1 = nack (sticky)
- any other address reads 'hdead
REQ-005 lb_wr_valid and lb_rd_valid SHALL each assert one cycle after lb_wr_en / lb_rd_en. lb_rd_data SHALL be registered in the same cycle as lb_rd_valid.
REQ-006 A start write SHALL be accepted only in IDLE. Writes to CFG_DATA while busy SHALL be ignored. Both cases SHALL still be acknowledged.
REQ-007 An accepted start SHALL clear nack, latch CFG_DATA into the shift logic, and enter START on the next cycle, with busy = 1 from that cycle.
REQ-008 The quarter counter SHALL run from 0 to P_SCL_QTR_DIV-1, emit a one-cycle qtick at the wrap, and be held at 0 in IDLE.
REQ-009 Each bit slot SHALL be 4 quarters (q0..q3):
- SCL = 0 in q0 and q3, SCL = 1 in q1 and q2
- SDA SHALL update only at the start of q0
- ACK SHALL be sampled on the qtick ending q1
REQ-010 The FSM states SHALL be IDLE, START, SHIFT, ACK, STOP, with these transitions:
- IDLE -> START on an accepted start
- START -> SHIFT after 4 quarters
- SHIFT -> ACK after 8 bits
- ACK -> SHIFT if the byte count < 2 and ACK is received
- ACK -> STOP if the byte count = 2, or on NACK
- STOP -> IDLE after 4 quarters
REQ-011 START timing SHALL be: SCL = 1 and SDA released in q0-q1; SDA pulled low from q2; SCL = 0 in q3.
REQ-012 STOP timing SHALL be: SDA low and SCL = 0 in q0; SCL = 1 from q1; SDA released from q2 onward.
REQ-013 Bytes SHALL be sent MSB first, in this order:
- byte 0 = {P_DEV_ADDR, 1'b0}
- byte 1 = {reg_addr[6:0], reg_data[8]}
- byte 2 = reg_data[7:0]
REQ-014 During ACK slots i2c_sda_oe SHALL be 0. A sampled i2c_sda_i = 1 SHALL set nack and abort to STOP.
REQ-015 A full transaction SHALL take 116 quarters (4 START + 27×4 bit slots + 4 STOP). IDLE SHALL be re-entered at 116×P_SCL_QTR_DIV+1 cycles after the lb_wr_en cycle.
REQ-016 cfg_done_p SHALL pulse once in the cycle the FSM returns to IDLE, for both completed and aborted transactions.
REQ-017 In IDLE, i2c_scl SHALL be 1 and i2c_sda_oe SHALL be 0. i2c_sda_o SHALL be tied to 0.
REQ-018 If lb_wr_en and lb_rd_en occur in the same cycle, both SHALL be serviced, and the read SHALL return the pre-write value.

Reset
REQ-019 On reset:
- FSM = IDLE, counters = 0
- CFG_DATA = 0, nack = 0, busy = 0
- i2c_scl = 1, i2c_sda_oe = 0, cfg_done_p = 0
- lb_wr_valid = lb_rd_valid = 0, lb_rd_data = 0
REQ-020 Reset asserted mid-transaction SHALL immediately release SDA and drive SCL high, with no STOP generated and no cfg_done_p.

Verification
REQ-021 With P_SCL_QTR_DIV = 4, write CFG_DATA = 0x1E00 then start -> the bus carries 0x34 ACK, 0x1E ACK, 0x00 ACK, STOP; cfg_done_p pulses at cycle 465 after start; status reads 0x0000.
REQ-022 The slave NACKs byte 0 -> STOP follows immediately after the ACK slot; status = 0x0002; cfg_done_p pulses once.
REQ-023 A start write while busy, with CFG_DATA changed -> wr_valid pulses; the in-flight bytes are unchanged; no second transaction runs.
REQ-024 Reset mid-byte-1 -> the next cycle shows scl = 1 and sda_oe = 0; status reads 0; a new start then works normally.
REQ-025 Read of 0x55 -> 'hdead with rd_valid one cycle later. CFG_DATA = 0x01FF is sent as bytes 0x01, 0xFF.

Source files
------------

// File: rtl/syn_wm8731_i2c_cfg_ctrl.sv
// rtl/syn_wm8731_i2c_cfg_ctrl.sv - I2C write-only configuration master for the WM8731 codec
// A local-bus register set triggers a 3-byte I2C write: device address, register address, register data.
module syn_wm8731_i2c_cfg_ctrl #(
  parameter int         P_LB_DATA_W   = 16,
  parameter int         P_LB_ADDR_W   = 8,
  parameter int         P_SCL_QTR_DIV = 125,
  parameter logic [6:0] P_DEV_ADDR    = 7'h1A
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync_l,
  input  logic                   lb_wr_en,
  input  logic                   lb_rd_en,
  input  logic [P_LB_ADDR_W-1:0] lb_addr,
  input  logic [P_LB_DATA_W-1:0] lb_wr_data,
  output logic                   lb_wr_valid,
  output logic                   lb_rd_valid,
  output logic [P_LB_DATA_W-1:0] lb_rd_data,
  output logic                   i2c_scl,
  output logic                   i2c_sda_o,
  output logic                   i2c_sda_oe,
  input  logic                   i2c_sda_i,
  output logic                   cfg_done_p
);

  localparam int QW = $clog2(P_SCL_QTR_DIV + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [P_LB_ADDR_W-1:0] A_CTRL = P_LB_ADDR_W'(8'h20);
  localparam logic [P_LB_ADDR_W-1:0] A_DATA = P_LB_ADDR_W'(8'h21);
  localparam logic [P_LB_ADDR_W-1:0] A_STAT = P_LB_ADDR_W'(8'h22);
  localparam logic [P_LB_DATA_W-1:0] RD_DEAD = P_LB_DATA_W'(16'hdead);

  logic [2:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    qidx;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [15:0]   cfg_data;
  logic [15:0]   tx_data;
  logic [7:0]    shreg;
  logic          nack;
  logic          busy;
  logic          qtick;
  logic          slot_end;
  logic          start_ok;
  logic [P_LB_DATA_W-1:0] rd_mux;

  assign busy      = (state != S_IDLE);
  assign qtick     = busy && (qcnt == QW'(P_SCL_QTR_DIV - 1));
  assign slot_end  = qtick && (qidx == 2'd3);
  assign start_ok  = lb_wr_en && (lb_addr == A_CTRL) && lb_wr_data[0] && !busy;
  assign i2c_sda_o = 1'b0;

  always_comb begin
    rd_mux = RD_DEAD;
    case (lb_addr)
      A_CTRL:  rd_mux = '0;
      A_DATA:  rd_mux = P_LB_DATA_W'(cfg_data);
      A_STAT:  rd_mux = P_LB_DATA_W'({nack, busy});
      default: rd_mux = RD_DEAD;
    endcase
  end

  // Bus pins decode straight from state flops so reset releases the bus immediately.
  always_comb begin
    i2c_scl    = 1'b1;
    i2c_sda_oe = 1'b0;
    case (state)
      S_START: begin
        i2c_scl    = (qidx != 2'd3);
        i2c_sda_oe = qidx[1];
      end
      S_SHIFT: begin
        i2c_scl    = qidx[1] ^ qidx[0];
        i2c_sda_oe = ~shreg[7];
      end
      S_ACK: begin
        i2c_scl    = qidx[1] ^ qidx[0];
        i2c_sda_oe = 1'b0;
      end
      S_STOP: begin
        i2c_scl    = (qidx != 2'd0);
        i2c_sda_oe = ~qidx[1];
      end
      default: begin
        i2c_scl    = 1'b1;
        i2c_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      lb_wr_valid <= 1'b0;
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
      cfg_data    <= '0;
    end else begin
      lb_wr_valid <= lb_wr_en;
      lb_rd_valid <= lb_rd_en;
      if (lb_rd_en)
        lb_rd_data <= rd_mux;
      if (lb_wr_en && (lb_addr == A_DATA) && !busy)
        cfg_data <= lb_wr_data[15:0];
    end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      qcnt <= '0;
      qidx <= 2'd0;
    end else if (!busy || qtick) begin
      qcnt <= '0;
      qidx <= busy ? qidx + 2'd1 : 2'd0;
    end else begin
      qcnt <= qcnt + QW'(1);
    end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 2'd0;
      tx_data    <= '0;
      shreg      <= '0;
      nack       <= 1'b0;
      cfg_done_p <= 1'b0;
    end else begin
      cfg_done_p <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          state    <= S_START;
          nack     <= 1'b0;
          tx_data  <= cfg_data;
          shreg    <= {P_DEV_ADDR, 1'b0};
          bit_cnt  <= 3'd0;
          byte_cnt <= 2'd0;
        end
        S_START: if (slot_end) state <= S_SHIFT;
        S_SHIFT: if (slot_end) begin
          if (bit_cnt == 3'd7) begin
            state   <= S_ACK;
            bit_cnt <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
        S_ACK: begin
          // Slave drives ACK while SCL is high; sample at the end of q1.
          if (qtick && (qidx == 2'd1) && i2c_sda_i)
            nack <= 1'b1;
          if (slot_end) begin
            if (nack || (byte_cnt == 2'd2)) begin
              state <= S_STOP;
            end else begin
              state    <= S_SHIFT;
              byte_cnt <= byte_cnt + 2'd1;
              shreg    <= (byte_cnt == 2'd0) ? tx_data[15:8] : tx_data[7:0];
            end
          end
        end
        S_STOP: if (slot_end) begin
          state      <= S_IDLE;
          cfg_done_p <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_wm8731_i2c_cfg_ctrl.sv
// tb/tb_syn_wm8731_i2c_cfg_ctrl.sv - bench for syn_wm8731_i2c_cfg_ctrl
// Bus-level model of the expected SCL/SDA waveform plus an I2C slave that decodes and ACKs bytes.
module tb_syn_wm8731_i2c_cfg_ctrl;
  localparam int DIV = 4;
  localparam logic [7:0] A_CTRL = 8'h20;
  localparam logic [7:0] A_DATA = 8'h21;
  localparam logic [7:0] A_STAT = 8'h22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic wr_valid, rd_valid, scl, sda_o, sda_oe, sda_i, done;
  logic [15:0] rd_data;
  logic slave_pull = 1'b0;

  always #5 clk = ~clk;
  assign sda_i = ~(sda_oe | slave_pull);

  syn_wm8731_i2c_cfg_ctrl #(
    .P_LB_DATA_W(16), .P_LB_ADDR_W(8), .P_SCL_QTR_DIV(DIV), .P_DEV_ADDR(7'h1A)
  ) dut (
    .clk_ir(clk), .rst_sync_l(rst_n), .lb_wr_en(wr_en), .lb_rd_en(rd_en),
    .lb_addr(addr), .lb_wr_data(wdata), .lb_wr_valid(wr_valid), .lb_rd_valid(rd_valid),
    .lb_rd_data(rd_data), .i2c_scl(scl), .i2c_sda_o(sda_o), .i2c_sda_oe(sda_oe),
    .i2c_sda_i(sda_i), .cfg_done_p(done)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: one transaction at a time.
  bit txn_valid = 1'b0;
  int t0 = 0;
  int nack_byte = 3;
  int pending_nack = 3;
  logic [7:0] tb_bytes [3];
  logic [15:0] m_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int end_cyc();
    int nb;
    nb = (nack_byte > 2) ? 2 : nack_byte;
    return 4 * (2 + 9 * (nb + 1)) * DIV;
  endfunction

  function automatic bit m_busy(input int c);
    return txn_valid && (c >= t0 + 1) && (c < t0 + 1 + end_cyc());
  endfunction

  // {scl, sda_oe} for quarter k of the transaction
  function automatic logic [1:0] exp_bus(input int k);
    int slot, q, last, j, bidx, bit_i;
    slot = k / 4;
    q    = k % 4;
    last = end_cyc() / (4 * DIV) - 1;
    if (slot == 0)    return {q != 3, q >= 2};
    if (slot == last) return {q != 0, q < 2};
    j = slot - 1;
    bidx = j / 9;
    bit_i = j % 9;
    if (bit_i == 8) return {(q == 1) || (q == 2), 1'b0};
    return {(q == 1) || (q == 2), ~tb_bytes[bidx][7 - bit_i]};
  endfunction

  always @(negedge clk) begin
    int d;
    logic [1:0] e;
    logic e_done;
    d = cyc - t0 - 1;
    e = 2'b10;
    e_done = 1'b0;
    if (txn_valid && d >= 0 && d < end_cyc()) e = exp_bus(d / DIV);
    if (txn_valid && d == end_cyc()) e_done = 1'b1;
    check("scl", scl, e[1]);
    check("sda_oe", sda_oe, e[0]);
    check("cfg_done_p", done, e_done);
    check("sda_o", sda_o, 1'b0);
  end

  // I2C slave: decodes bytes on SCL rise, drives ACK/NACK after each 8th bit.
  logic p_scl = 1'b1, p_line = 1'b1;
  int bcnt = 0, mon_n = 0, done_cnt = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] mon_byte [4];
  logic mon_ack [4];

  always @(negedge clk) begin
    logic line;
    line = sda_i;
    if (done) done_cnt++;
    if (!rst_n) begin
      bcnt = 0;
      slave_pull = 1'b0;
    end else if (p_scl && scl && p_line && !line) begin
      bcnt = 0;
      mon_n = 0;
      slave_pull = 1'b0;
    end else if (!p_scl && scl) begin
      if (bcnt % 9 == 8) begin
        if (mon_n > 0 && mon_n <= 4) mon_ack[mon_n - 1] = line;
      end else begin
        sh = {sh[6:0], line};
      end
      bcnt++;
      if (bcnt % 9 == 8 && mon_n < 4) begin
        mon_byte[mon_n] = sh;
        mon_n++;
      end
    end else if (p_scl && !scl) begin
      slave_pull = (bcnt % 9 == 8) && (bcnt / 9 != nack_byte);
    end
    p_scl = scl;
    p_line = line;
  end

  task automatic bus(input logic wr, input logic rd, input logic [7:0] a,
                     input logic [15:0] wd, output logic [15:0] rv);
    logic [15:0] exp_rd;
    logic bz;
    @(posedge clk);
    #1;
    bz = m_busy(cyc);
    case (a)
      A_CTRL:  exp_rd = 16'h0000;
      A_DATA:  exp_rd = m_data;
      A_STAT:  exp_rd = {14'd0, txn_valid && (nack_byte < 3) && !bz, bz};
      default: exp_rd = 16'hdead;
    endcase
    wr_en = wr; rd_en = rd; addr = a; wdata = wd;
    if (wr && a == A_DATA && !bz) m_data = wd;
    if (wr && a == A_CTRL && wd[0] && !bz) begin
      txn_valid = 1'b1;
      t0 = cyc;
      nack_byte = pending_nack;
      tb_bytes[0] = {7'h1A, 1'b0};
      tb_bytes[1] = m_data[15:8];
      tb_bytes[2] = m_data[7:0];
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("wr_valid", wr_valid, wr);
    check("rd_valid", rd_valid, rd);
    if (rd) check("rd_data", rd_data, exp_rd);
    rv = rd_data;
  endtask

  task automatic start_txn(input logic [15:0] data, input int nb);
    logic [15:0] rv;
    pending_nack = nb;
    bus(1'b1, 1'b0, A_DATA, data, rv);
    bus(1'b1, 1'b0, A_CTRL, 16'h0001, rv);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 3000, 1'b1);
    dc = cyc - t0;
  endtask

  task automatic check_bytes(input string name);
    int nsent;
    nsent = ((nack_byte > 2) ? 2 : nack_byte) + 1;
    check({name, "_nbytes"}, mon_n, nsent);
    for (int i = 0; i < nsent; i++) begin
      check({name, "_byte"}, mon_byte[i], tb_bytes[i]);
      check({name, "_ack"}, mon_ack[i], (i == nack_byte) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    logic [15:0] rv;
    int dc, dcnt0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_scl", scl, 1'b1);
    check("rst_sda_oe", sda_oe, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    bus(1'b0, 1'b1, A_CTRL, 16'h0, rv);
    bus(1'b0, 1'b1, A_DATA, 16'h0, rv);
    bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
    bus(1'b0, 1'b1, 8'h55, 16'h0, rv);
    check("lit_dead", rv, 16'hdead);

    // Nominal transaction, bytes 0x34 0x1E 0x00
    start_txn(16'h1E00, 3);
    wait_done(dc);
    check("lit_done_cycle", dc, 465);
    check("lit_b0", mon_byte[0], 8'h34);
    check("lit_b1", mon_byte[1], 8'h1E);
    check("lit_b2", mon_byte[2], 8'h00);
    check_bytes("nominal");
    bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
    check("lit_status_ok", rv, 16'h0000);

    // NACK on the address byte
    dcnt0 = done_cnt;
    start_txn(16'h1E00, 0);
    wait_done(dc);
    check("lit_nack_done_cycle", dc, 177);
    repeat (20) @(negedge clk);
    check("nack_done_once", done_cnt - dcnt0, 1);
    check_bytes("nack0");
    bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
    check("lit_status_nack", rv, 16'h0002);

    // Start and data writes while busy are acknowledged but have no effect
    dcnt0 = done_cnt;
    start_txn(16'h1234, 3);
    repeat (100) @(posedge clk);
    bus(1'b1, 1'b0, A_DATA, 16'hABCD, rv);
    bus(1'b1, 1'b0, A_CTRL, 16'h0001, rv);
    bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
    check("lit_status_busy", rv, 16'h0001);
    wait_done(dc);
    repeat (600) @(negedge clk);
    check("busy_done_once", done_cnt - dcnt0, 1);
    check("lit_busy_b1", mon_byte[1], 8'h12);
    check_bytes("busy");
    bus(1'b0, 1'b1, A_DATA, 16'h0, rv);
    check("lit_data_kept", rv, 16'h1234);

    // Reset in the middle of byte 1
    dcnt0 = done_cnt;
    start_txn(16'h5678, 3);
    repeat (60 * DIV) @(posedge clk);
    #1 rst_n = 1'b0;
    txn_valid = 1'b0;
    m_data = 16'h0000;
    @(negedge clk);
    check("lit_rst_scl", scl, 1'b1);
    check("lit_rst_oe", sda_oe, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check("rst_no_done", done_cnt - dcnt0, 0);
    bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
    check("lit_rst_status", rv, 16'h0000);
    start_txn(16'h01FF, 3);
    wait_done(dc);
    check("lit_01ff_b1", mon_byte[1], 8'h01);
    check("lit_01ff_b2", mon_byte[2], 8'hFF);
    check_bytes("after_rst");

    // Simultaneous write and read returns the old value
    bus(1'b1, 1'b1, A_DATA, 16'h5A5A, rv);
    check("lit_rw_old", rv, 16'h01FF);
    bus(1'b0, 1'b1, A_DATA, 16'h0, rv);

    for (int i = 0; i < 5; i++) begin
      logic [15:0] d;
      int nb;
      d = 16'($urandom);
      nb = $urandom_range(0, 3);
      start_txn(d, nb);
      wait_done(dc);
      check("rand_done_cycle", dc, end_cyc() + 1);
      check_bytes("rand");
      bus(1'b0, 1'b1, A_STAT, 16'h0, rv);
      bus(1'b0, 1'b1, 8'($urandom_range(0, 255)), 16'h0, rv);
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
